// File: rtl/mig_app_responder.sv
// mig_app_responder
//   BRAM-backed stand-in for a MIG 7-series controller plus DDR3, seen through
//   the app_* user interface. An initiator written against the real MIG can run
//   unchanged against this block in simulation or in DRAM-less builds.
//
//   Handshakes: a command transfers on a clk edge where app_en & app_rdy; a write
//   beat transfers on a clk edge where app_wdf_wren & app_wdf_rdy. Both readies
//   are registers that reflect the FIFO occupancy at the start of the cycle, so a
//   full FIFO never takes a push, even in a cycle where it also pops. Read data
//   has no backpressure: app_rd_data_valid is a one-cycle pulse.
//
//   Ports
//     clk, srst_n                  clock, synchronous active-low reset
//     app_addr/app_cmd/app_en      command (000 write, 001 read), rdy = app_rdy
//     app_wdf_data/mask/end/wren   write beat (mask bit 1 = byte kept), rdy = app_wdf_rdy
//     app_rd_data/_valid/_end      read return, RD_LATENCY cycles after execution
//     init_calib_complete          rises CALIB_CYCLES cycles after reset release
//     err_cmd, err_align           sticky: bad opcode / misaligned address accepted
module mig_app_responder #(
  parameter int ADDR_WIDTH   = 29,
  parameter int DATA_WIDTH   = 128,
  parameter int MEM_AW       = 10,
  parameter int FIFO_AW      = 2,
  parameter int RD_LATENCY   = 4,
  parameter int CALIB_CYCLES = 64,
  parameter int STALL_EVERY  = 0
) (
  input  logic                    clk,
  input  logic                    srst_n,
  input  logic [ADDR_WIDTH-1:0]   app_addr,
  input  logic [2:0]              app_cmd,
  input  logic                    app_en,
  output logic                    app_rdy,
  input  logic [DATA_WIDTH-1:0]   app_wdf_data,
  input  logic [DATA_WIDTH/8-1:0] app_wdf_mask,
  input  logic                    app_wdf_end,
  input  logic                    app_wdf_wren,
  output logic                    app_wdf_rdy,
  output logic [DATA_WIDTH-1:0]   app_rd_data,
  output logic                    app_rd_data_valid,
  output logic                    app_rd_data_end,
  output logic                    init_calib_complete,
  output logic                    err_cmd,
  output logic                    err_align
);

  localparam int NBYTES  = DATA_WIDTH / 8;
  localparam int DEPTH   = 1 << FIFO_AW;
  localparam int CAL_W   = (CALIB_CYCLES > 1) ? $clog2(CALIB_CYCLES) : 1;
  localparam int STALL_W = (STALL_EVERY > 1) ? $clog2(STALL_EVERY) : 1;
  localparam logic [CAL_W-1:0]   CAL_LAST   = CAL_W'(CALIB_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'((STALL_EVERY > 0) ? STALL_EVERY - 1 : 0);
  localparam logic [FIFO_AW:0]   FIFO_FULL  = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [2:0]         CMD_WR     = 3'b000;
  localparam logic [2:0]         CMD_RD     = 3'b001;

  // Command FIFO: opcode and memory entry index only; the low address bits are
  // only needed for the alignment flag at acceptance.
  logic [2:0]         cq_cmd [DEPTH];
  logic [MEM_AW-1:0]  cq_idx [DEPTH];
  logic [FIFO_AW-1:0] cq_wp, cq_rp;
  logic [FIFO_AW:0]   cq_cnt, cq_cnt_nx;

  logic [DATA_WIDTH-1:0] wq_data [DEPTH];
  logic [NBYTES-1:0]     wq_mask [DEPTH];
  logic [FIFO_AW-1:0]    wq_wp, wq_rp;
  logic [FIFO_AW:0]      wq_cnt, wq_cnt_nx;

  logic [DATA_WIDTH-1:0] mem [2**MEM_AW];

  logic [CAL_W-1:0]   cal_cnt;
  logic               calib_nx;
  logic [STALL_W-1:0] stall_cnt, stall_cnt_nx;
  logic               stall_nx;

  logic              cmd_push, wdf_push, cmd_pop, wdf_pop, do_read;
  logic [2:0]        head_cmd;
  logic [MEM_AW-1:0] head_idx;

  logic [RD_LATENCY-1:0] rd_vld;
  logic [DATA_WIDTH-1:0] rd_dat [RD_LATENCY];

  // High address bits alias and app_wdf_end carries no information in BL8 4:1.
  logic unused_inputs;
  assign unused_inputs = ^{app_wdf_end, app_addr[ADDR_WIDTH-1:MEM_AW+3]};

  assign cmd_push = app_en & app_rdy;
  assign wdf_push = app_wdf_wren & app_wdf_rdy;
  assign head_cmd = cq_cmd[cq_rp];
  assign head_idx = cq_idx[cq_rp];

  // A write at the head waits for its data beat and blocks everything behind it,
  // which keeps beats paired with write commands strictly in order.
  always_comb begin
    cmd_pop = 1'b0;
    wdf_pop = 1'b0;
    if (cq_cnt != '0) begin
      if (head_cmd == CMD_WR) begin
        cmd_pop = (wq_cnt != '0);
        wdf_pop = (wq_cnt != '0);
      end else begin
        cmd_pop = 1'b1;
      end
    end
  end

  assign do_read   = cmd_pop & (head_cmd == CMD_RD);
  assign cq_cnt_nx = cq_cnt + {{FIFO_AW{1'b0}}, cmd_push} - {{FIFO_AW{1'b0}}, cmd_pop};
  assign wq_cnt_nx = wq_cnt + {{FIFO_AW{1'b0}}, wdf_push} - {{FIFO_AW{1'b0}}, wdf_pop};
  assign calib_nx  = init_calib_complete | (cal_cnt == CAL_LAST);

  // The stall pulse lasts only the cycle after the wrapping acceptance.
  always_comb begin
    stall_cnt_nx = stall_cnt;
    stall_nx     = 1'b0;
    if (STALL_EVERY > 0 && cmd_push) begin
      if (stall_cnt == STALL_LAST) begin
        stall_cnt_nx = '0;
        stall_nx     = 1'b1;
      end else begin
        stall_cnt_nx = stall_cnt + STALL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      cal_cnt             <= '0;
      init_calib_complete <= 1'b0;
      stall_cnt           <= '0;
      app_rdy             <= 1'b0;
      app_wdf_rdy         <= 1'b0;
      cq_wp               <= '0;
      cq_rp               <= '0;
      cq_cnt              <= '0;
      wq_wp               <= '0;
      wq_rp               <= '0;
      wq_cnt              <= '0;
      err_cmd             <= 1'b0;
      err_align           <= 1'b0;
    end else begin
      if (!init_calib_complete && cal_cnt != CAL_LAST) cal_cnt <= cal_cnt + CAL_W'(1);
      init_calib_complete <= calib_nx;
      stall_cnt           <= stall_cnt_nx;
      app_rdy             <= calib_nx & (cq_cnt_nx != FIFO_FULL) & ~stall_nx;
      app_wdf_rdy         <= calib_nx & (wq_cnt_nx != FIFO_FULL);
      cq_cnt              <= cq_cnt_nx;
      wq_cnt              <= wq_cnt_nx;
      if (cmd_push) cq_wp <= cq_wp + FIFO_AW'(1);
      if (cmd_pop)  cq_rp <= cq_rp + FIFO_AW'(1);
      if (wdf_push) wq_wp <= wq_wp + FIFO_AW'(1);
      if (wdf_pop)  wq_rp <= wq_rp + FIFO_AW'(1);
      if (cmd_push) begin
        if (app_cmd != CMD_WR && app_cmd != CMD_RD) err_cmd <= 1'b1;
        if (app_addr[2:0] != 3'b000) err_align <= 1'b1;
      end
    end
  end

  // FIFO storage needs no reset; flushing is done through the pointers.
  always_ff @(posedge clk) begin
    if (cmd_push) begin
      cq_cmd[cq_wp] <= app_cmd;
      cq_idx[cq_wp] <= app_addr[MEM_AW+2:3];
    end
    if (wdf_push) begin
      wq_data[wq_wp] <= app_wdf_data;
      wq_mask[wq_wp] <= app_wdf_mask;
    end
  end

  // Memory survives reset; a write that would execute on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (srst_n && wdf_pop) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (!wq_mask[wq_rp][b]) mem[head_idx][b*8 +: 8] <= wq_data[wq_rp][b*8 +: 8];
      end
    end
  end

  // Read pipeline: stage 0 is loaded on the pop edge, the last stage drives the
  // outputs. Data stages only advance behind a valid, so app_rd_data holds.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      rd_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) rd_dat[i] <= '0;
    end else begin
      rd_vld[0] <= do_read;
      if (do_read) rd_dat[0] <= mem[head_idx];
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_vld[i] <= rd_vld[i-1];
        if (rd_vld[i-1]) rd_dat[i] <= rd_dat[i-1];
      end
    end
  end

  assign app_rd_data       = rd_dat[RD_LATENCY-1];
  assign app_rd_data_valid = rd_vld[RD_LATENCY-1];
  assign app_rd_data_end   = rd_vld[RD_LATENCY-1];

endmodule

// File: tb/tb_mig_app_responder.sv
// Directed bench for mig_app_responder. dut0 runs without stalls, dut1 with
// STALL_EVERY=3. Inputs change and outputs are sampled on the falling edge.
module tb_mig_app_responder;

  localparam int AW = 29;
  localparam int DW = 128;
  localparam int NB = DW / 8;
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          srst_n;
  logic [AW-1:0] app_addr [2];
  logic [2:0]    app_cmd [2];
  logic          app_en [2];
  logic          app_rdy [2];
  logic [DW-1:0] app_wdf_data [2];
  logic [NB-1:0] app_wdf_mask [2];
  logic          app_wdf_end [2];
  logic          app_wdf_wren [2];
  logic          app_wdf_rdy [2];
  logic [DW-1:0] app_rd_data [2];
  logic          app_rd_data_valid [2];
  logic          app_rd_data_end [2];
  logic          init_calib_complete [2];
  logic          err_cmd [2];
  logic          err_align [2];

  mig_app_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_AW(10), .FIFO_AW(2),
    .RD_LATENCY(4), .CALIB_CYCLES(64), .STALL_EVERY(0)) dut0 (
    .clk(clk), .srst_n(srst_n), .app_addr(app_addr[0]), .app_cmd(app_cmd[0]),
    .app_en(app_en[0]), .app_rdy(app_rdy[0]), .app_wdf_data(app_wdf_data[0]),
    .app_wdf_mask(app_wdf_mask[0]), .app_wdf_end(app_wdf_end[0]),
    .app_wdf_wren(app_wdf_wren[0]), .app_wdf_rdy(app_wdf_rdy[0]),
    .app_rd_data(app_rd_data[0]), .app_rd_data_valid(app_rd_data_valid[0]),
    .app_rd_data_end(app_rd_data_end[0]), .init_calib_complete(init_calib_complete[0]),
    .err_cmd(err_cmd[0]), .err_align(err_align[0]));

  mig_app_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_AW(10), .FIFO_AW(2),
    .RD_LATENCY(4), .CALIB_CYCLES(64), .STALL_EVERY(3)) dut1 (
    .clk(clk), .srst_n(srst_n), .app_addr(app_addr[1]), .app_cmd(app_cmd[1]),
    .app_en(app_en[1]), .app_rdy(app_rdy[1]), .app_wdf_data(app_wdf_data[1]),
    .app_wdf_mask(app_wdf_mask[1]), .app_wdf_end(app_wdf_end[1]),
    .app_wdf_wren(app_wdf_wren[1]), .app_wdf_rdy(app_wdf_rdy[1]),
    .app_rd_data(app_rd_data[1]), .app_rd_data_valid(app_rd_data_valid[1]),
    .app_rd_data_end(app_rd_data_end[1]), .init_calib_complete(init_calib_complete[1]),
    .err_cmd(err_cmd[1]), .err_align(err_align[1]));

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Read-return monitor.
  int vcnt0 = 0;
  int vcnt1 = 0;
  logic [DW-1:0] got_q1 [$];

  always @(negedge clk) begin
    if (app_rd_data_valid[0] === 1'b1) vcnt0++;
    if (app_rd_data_valid[1] === 1'b1) begin
      vcnt1++;
      got_q1.push_back(app_rd_data[1]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) passes = passes + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    return {4{32'hC0DE_0000 + 32'(i)}};
  endfunction

  task automatic chk_reset(input int d, input string tag);
    chk({tag, "_app_rdy"},     app_rdy[d], 0);
    chk({tag, "_wdf_rdy"},     app_wdf_rdy[d], 0);
    chk({tag, "_rd_valid"},    app_rd_data_valid[d], 0);
    chk({tag, "_rd_end"},      app_rd_data_end[d], 0);
    chk({tag, "_rd_data"},     app_rd_data[d], 0);
    chk({tag, "_calib"},       init_calib_complete[d], 0);
    chk({tag, "_err_cmd"},     err_cmd[d], 0);
    chk({tag, "_err_align"},   err_align[d], 0);
  endtask

  // Presents a command, waits for app_rdy, returns on the falling edge after acceptance.
  task automatic issue_cmd(input int d, input logic [2:0] c, input logic [AW-1:0] a);
    int t;
    app_en[d] = 1'b1;
    app_cmd[d] = c;
    app_addr[d] = a;
    t = 0;
    while (app_rdy[d] !== 1'b1 && t < 200) begin
      step(1);
      t++;
    end
    chk("cmd_accept_rdy", app_rdy[d], 1);
    step(1);
    app_en[d] = 1'b0;
  endtask

  task automatic issue_wdf(input int d, input logic [DW-1:0] data, input logic [NB-1:0] mask);
    int t;
    app_wdf_wren[d] = 1'b1;
    app_wdf_data[d] = data;
    app_wdf_mask[d] = mask;
    t = 0;
    while (app_wdf_rdy[d] !== 1'b1 && t < 200) begin
      step(1);
      t++;
    end
    chk("wdf_accept_rdy", app_wdf_rdy[d], 1);
    step(1);
    app_wdf_wren[d] = 1'b0;
  endtask

  task automatic wait_rd(input int d, input logic [DW-1:0] e, input string tag);
    int t;
    t = 0;
    while (app_rd_data_valid[d] !== 1'b1 && t < 20) begin
      step(1);
      t++;
    end
    chk({tag, "_valid"}, app_rd_data_valid[d], 1);
    chk({tag, "_end"}, app_rd_data_end[d], 1);
    chk(tag, app_rd_data[d], e);
    step(1);
  endtask

  initial begin
    logic [DW-1:0] d1, e3;
    logic [3:0] exp_r;
    logic [7:0] exp_s;
    int k, t, v0;

    d1 = 128'haabbccdd_eeff0011_22334455_66778899;
    e3 = {64'h1111_1111_1111_1111, 64'h22334455_66778899};

    srst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      app_addr[d] = '0;
      app_cmd[d] = '0;
      app_en[d] = 1'b0;
      app_wdf_data[d] = '0;
      app_wdf_mask[d] = '0;
      app_wdf_end[d] = 1'b1;
      app_wdf_wren[d] = 1'b0;
    end
    step(3);
    chk_reset(0, "rst0");
    chk_reset(1, "rst1");

    // Calibration: rises after the 64th edge following release.
    srst_n = 1'b1;
    for (int i = 1; i < 64; i++) begin
      step(1);
      chk("calib_low", init_calib_complete[0], 0);
      chk("cal_app_rdy_low", app_rdy[0], 0);
      chk("cal_wdf_rdy_low", app_wdf_rdy[0], 0);
    end
    step(1);
    chk("calib_high0", init_calib_complete[0], 1);
    chk("calib_high1", init_calib_complete[1], 1);
    chk("cal_app_rdy_high", app_rdy[0], 1);
    chk("cal_wdf_rdy_high", app_wdf_rdy[0], 1);
    chk("cal_no_valid0", vcnt0, 0);
    chk("cal_no_valid1", vcnt1, 0);

    // Write with data three cycles after the command, then read back.
    issue_cmd(0, CMD_WR, 29'h08);
    step(2);
    issue_wdf(0, d1, '0);
    issue_cmd(0, CMD_RD, 29'h08);
    chk("rd_lat_early", app_rd_data_valid[0], 0);
    for (int i = 1; i < 4; i++) begin
      step(1);
      chk("rd_lat_early", app_rd_data_valid[0], 0);
    end
    step(1);
    chk("rd_lat_valid", app_rd_data_valid[0], 1);
    chk("rd_lat_end", app_rd_data_end[0], 1);
    chk("rd_lat_data", app_rd_data[0], d1);
    step(1);
    chk("rd_pulse_valid_off", app_rd_data_valid[0], 0);
    chk("rd_pulse_end_off", app_rd_data_end[0], 0);
    chk("rd_data_hold", app_rd_data[0], d1);

    // Masked write (data before command): upper 8 bytes replaced.
    issue_wdf(0, {16{8'h11}}, 16'h00FF);
    issue_cmd(0, CMD_WR, 29'h08);
    issue_cmd(0, CMD_RD, 29'h08);
    wait_rd(0, e3, "mask_merge");
    step(3);

    // Five writes with no data: FIFO fills after four, then drains as beats arrive.
    app_cmd[0] = CMD_WR;
    app_en[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      app_addr[0] = 29'(16 + 8 * i);
      chk("fill_rdy", app_rdy[0], 1);
      step(1);
    end
    app_addr[0] = 29'h30;
    chk("full_rdy_low", app_rdy[0], 0);
    step(1);
    chk("full_rdy_hold", app_rdy[0], 0);
    step(1);
    exp_r = 4'b1100;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) app_en[0] = 1'b0;
      app_wdf_wren[0] = 1'b1;
      app_wdf_data[0] = pat(16 + i);
      app_wdf_mask[0] = '0;
      chk("drain_wdf_rdy", app_wdf_rdy[0], 1);
      chk("drain_app_rdy", app_rdy[0], exp_r[i]);
      step(1);
    end
    issue_wdf(0, pat(20), '0);
    issue_cmd(0, CMD_RD, 29'h10);
    wait_rd(0, pat(16), "drain_first");
    issue_cmd(0, CMD_RD, 29'h30);
    wait_rd(0, pat(20), "drain_fifth");

    // STALL_EVERY=3: preload six entries, then stream six reads.
    for (int i = 0; i < 6; i++) begin
      issue_wdf(1, pat(i), '0);
      issue_cmd(1, CMD_WR, 29'(8 * i));
    end
    step(5);
    got_q1.delete();
    app_cmd[1] = CMD_RD;
    k = 0;
    exp_s = 8'b0111_0111;
    for (int c = 0; c < 8; c++) begin
      app_en[1] = (k < 6);
      app_addr[1] = 29'(8 * k);
      chk("stall_rdy", app_rdy[1], exp_s[c]);
      if (app_rdy[1] === 1'b1 && k < 6) k++;
      step(1);
    end
    app_en[1] = 1'b0;
    step(12);
    #1;
    chk("stall_ret_count", got_q1.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk("stall_ret_order", (i < got_q1.size()) ? got_q1[i] : '0, pat(i));
    end
    chk("stall_err_cmd", err_cmd[1], 0);
    chk("stall_err_align", err_align[1], 0);
    step(1);

    // Unsupported opcode at a misaligned address.
    chk("err_cmd_clean", err_cmd[0], 0);
    chk("err_align_clean", err_align[0], 0);
    v0 = vcnt0;
    issue_cmd(0, 3'b010, 29'h03);
    chk("err_cmd_set", err_cmd[0], 1);
    chk("err_align_set", err_align[0], 1);
    step(8);
    chk("bad_cmd_no_data", vcnt0, v0);

    // Reset while a read is in flight.
    issue_cmd(0, CMD_RD, 29'h08);
    srst_n = 1'b0;
    step(1);
    chk_reset(0, "midrst");
    step(1);
    srst_n = 1'b1;
    t = 0;
    while (init_calib_complete[0] !== 1'b1 && t < 200) begin
      step(1);
      t++;
    end
    chk("recal_done", init_calib_complete[0], 1);
    chk("recal_cycles", t, 64);
    chk("no_valid_after_rst", vcnt0, v0);
    chk("err_cmd_after_rst", err_cmd[0], 0);
    issue_cmd(0, CMD_RD, 29'h08);
    wait_rd(0, e3, "mem_retained");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
